// File: rtl/core_mc.sv
// ============================================================================
// core_mc -- multi-cycle RV32I/RV32E core with a single shared memory port.
//
// One FSM walks every instruction through FETCH -> DECODE -> EXEC -> [MEM] ->
// [WB] and back to FETCH. Instructions never overlap. Instruction fetch and
// data access share one valid/ready memory port. The register file, immediate
// decode, ALU and PC are all inside this block.
//
// Supported instructions: LUI, AUIPC, JAL, JALR, the six branches, LW, SW,
// OP-IMM and OP.
//
// Parameters
//   XLEN      datapath width (only 32 is meaningful for the RV32 encodings)
//   NREGS     32 (RV32I) or 16 (RV32E); the top register-index bits are ignored
//   RESET_PC  PC loaded by reset
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   mem_req    memory request valid
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   word-aligned address (valid while mem_req, else 0)
//   mem_wdata  store data (valid while mem_req && mem_we, else 0)
//   mem_rdata  read data, sampled on mem_req && mem_ready
//   mem_ready  transfer completes this cycle
//   retire     one-cycle pulse in the last cycle of each instruction
//   pc_o       PC of the instruction in flight
//   halted     core is parked in HALT
//
// Build option
//   CORE_MC_TRAP_EN  when defined, an illegal opcode or a misaligned
//                    jump/taken-branch target parks the core in HALT until
//                    reset. When undefined, illegal opcodes retire as NOPs,
//                    target bits [1:0] are cleared, and halted is tied low.
// ============================================================================
module core_mc #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            retire,
    output logic [XLEN-1:0] pc_o,
    output logic            halted
);

    localparam int RIDX = $clog2(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] ir_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] imm_reg;
    logic [XLEN-1:0] alu_out_reg;
    logic [XLEN-1:0] mdr_reg;
    logic [XLEN-1:0] rf [NREGS];

    // ------------------------------------------------------------------
    // Instruction field decode. ir_reg is stable from DECODE to the end of
    // the instruction, so these flags hold for the whole instruction.
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RIDX-1:0] rs1_idx, rs2_idx, rd_idx;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, illegal;

    assign opcode  = ir_reg[6:0];
    assign funct3  = ir_reg[14:12];
    // For RV32E the upper index bit is simply not looked at.
    assign rd_idx  = ir_reg[7 +: RIDX];
    assign rs1_idx = ir_reg[15 +: RIDX];
    assign rs2_idx = ir_reg[20 +: RIDX];

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR)   && (funct3 == 3'b000);
    // funct3 010/011 are not branch encodings.
    assign is_branch = (opcode == OP_BRANCH) && (funct3[2:1] != 2'b01);
    assign is_load   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    assign is_store  = (opcode == OP_STORE)  && (funct3 == 3'b010);
    assign is_opimm  = (opcode == OP_OPIMM);
    assign is_op     = (opcode == OP_OP);
    assign illegal   = !(is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                         is_load || is_store || is_opimm || is_op);

    // ------------------------------------------------------------------
    // Immediate decode (captured into imm_reg during DECODE).
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_dec;

    always_comb begin
        imm_dec = {{20{ir_reg[31]}}, ir_reg[31:20]};                         // I
        if (is_store)
            imm_dec = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};       // S
        else if (is_branch)
            imm_dec = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7],
                       ir_reg[30:25], ir_reg[11:8], 1'b0};                   // B
        else if (is_lui || is_auipc)
            imm_dec = {ir_reg[31:12], 12'b0};                                // U
        else if (is_jal)
            imm_dec = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12],
                       ir_reg[20], ir_reg[30:21], 1'b0};                     // J
    end

    // ------------------------------------------------------------------
    // ALU. Address generation (loads, stores, JALR), AUIPC and the JAL
    // target all reuse the adder by forcing funct3 to ADD.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op_a, op_b, alu_res, sra_res;
    logic [2:0]      alu_f3;
    logic [4:0]      shamt;

    assign op_a   = (is_auipc || is_jal) ? pc_reg : a_reg;
    assign op_b   = (is_op || is_branch) ? b_reg : imm_reg;
    assign alu_f3 = (is_op || is_opimm) ? funct3 : 3'b000;
    assign shamt  = op_b[4:0];
    // Kept in its own assignment so the arithmetic shift is evaluated in a
    // signed context.
    assign sra_res = $signed(op_a) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (alu_f3)
            3'b000: alu_res = (is_op && ir_reg[30]) ? (op_a - op_b) : (op_a + op_b);
            3'b001: alu_res = op_a << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100: alu_res = op_a ^ op_b;
            3'b101: alu_res = ir_reg[30] ? sra_res : (op_a >> shamt);
            3'b110: alu_res = op_a | op_b;
            3'b111: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition on the operands latched in DECODE.
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000: br_taken = (a_reg == b_reg);
            3'b001: br_taken = (a_reg != b_reg);
            3'b100: br_taken = ($signed(a_reg) <  $signed(b_reg));
            3'b101: br_taken = ($signed(a_reg) >= $signed(b_reg));
            3'b110: br_taken = (a_reg <  b_reg);
            3'b111: br_taken = (a_reg >= b_reg);
            default: br_taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] pc_plus4, br_target, br_next, jump_tgt;
    logic            exec_trap;

    assign pc_plus4  = pc_reg + 32'd4;
    assign br_target = pc_reg + imm_reg;

`ifdef CORE_MC_TRAP_EN
    // Any target that is not word aligned faults, so no masking is needed
    // beyond JALR's architectural clearing of bit 0.
    assign br_next   = br_target;
    assign jump_tgt  = is_jalr ? (alu_out_reg & ~32'd1) : alu_out_reg;
    // Evaluated in EXEC: alu_res is the jump target for JAL/JALR.
    assign exec_trap = illegal ||
                       (is_jal    && (alu_res[1:0] != 2'b00)) ||
                       (is_jalr   && alu_res[1]) ||
                       (is_branch && br_taken && (br_target[1:0] != 2'b00));
    assign halted    = (state_reg == S_HALT);
`else
    // Without trapping, misaligned targets are forced onto a word boundary.
    assign br_next   = br_target & ~32'd3;
    assign jump_tgt  = alu_out_reg & ~32'd3;
    assign exec_trap = 1'b0;
    assign halted    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Register file. x0 is never written, so it keeps its reset value 0.
    // ------------------------------------------------------------------
    logic            rf_we;
    logic [XLEN-1:0] wb_data;

    assign rf_we   = (state_reg == S_WB) && (rd_idx != '0);
    assign wb_data = is_lui                ? imm_reg  :
                     (is_jal || is_jalr)   ? pc_plus4 :
                     is_load               ? mdr_reg  :
                                             alu_out_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (rf_we) begin
            rf[rd_idx] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (exec_trap)
                    state_next = S_HALT;
                else if (is_branch || illegal)
                    state_next = S_FETCH;
                else if (is_load || is_store)
                    state_next = S_MEM;
                else
                    state_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready)
                    state_next = is_load ? S_WB : S_FETCH;
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // FSM: outputs. Everything is gated by reset so the port goes quiet
    // the moment reset asserts, even mid-transfer. The request fields come
    // only from registers that do not change while waiting for mem_ready,
    // which keeps them stable across wait states.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        if (reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_reg;
                end
                S_EXEC: begin
                    retire = (is_branch || illegal) && !exec_trap;
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = is_store;
                    mem_addr  = {alu_out_reg[XLEN-1:2], 2'b00};
                    mem_wdata = is_store ? b_reg : '0;
                    retire    = is_store && mem_ready;
                end
                S_WB: begin
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            imm_reg     <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready)
                        ir_reg <= mem_rdata;
                end
                S_DECODE: begin
                    a_reg   <= rf[rs1_idx];
                    b_reg   <= rf[rs2_idx];
                    imm_reg <= imm_dec;
                end
                S_EXEC: begin
                    alu_out_reg <= alu_res;
                    // A trapping instruction leaves the PC on itself.
                    if (!exec_trap) begin
                        if (is_branch)
                            pc_reg <= br_taken ? br_next : pc_plus4;
                        else if (illegal)
                            pc_reg <= pc_plus4;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_load)
                            mdr_reg <= mem_rdata;
                        else
                            pc_reg <= pc_plus4;
                    end
                end
                S_WB: begin
                    pc_reg <= (is_jal || is_jalr) ? jump_tgt : pc_plus4;
                end
                default: ;
            endcase
        end
    end

    assign pc_o = pc_reg;

endmodule

// File: tb/tb_core_mc.sv
// ============================================================================
// tb_core_mc -- directed test of core_mc with RESET_PC = 32'h100.
// A word-addressed memory model answers the shared port; a monitor on the
// falling edge drives mem_ready (with optional wait states), logs every
// transfer and retirement with a cycle number (cycle 0 = first cycle after
// reset release), and prints one line per transaction.
// ============================================================================
module tb_core_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
    logic        mem_ready = 1'b1;

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[9:2]];

    core_mc #(
        .XLEN     (32),
        .NREGS    (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .pc_o      (pc_o),
        .halted    (halted)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } xfer_t;

    xfer_t       xq[$];
    int          rq_cyc[$];
    logic [31:0] rq_pc[$];
    logic [31:0] stall_addr[$];
    int          cyc;
    int          stall_left;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v, r1, d;
        v = imm; r1 = rs1; d = rd;
        return {v[11:0], r1[4:0], f3, d[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [31:0] r1, r2, d;
        r1 = rs1; r2 = rs2; d = rd;
        return {f7, r2[4:0], r1[4:0], f3, d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v, r1, r2;
        v = imm; r1 = rs1; r2 = rs2;
        return {v[11:5], r2[4:0], r1[4:0], 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2,
                                          input int imm);
        logic [31:0] v, r1, r2;
        v = imm; r1 = rs1; r2 = rs2;
        return {v[12], v[10:5], r2[4:0], r1[4:0], f3, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input int rd, input logic [6:0] op);
        logic [31:0] d;
        d = rd;
        return {imm, d[4:0], op};
    endfunction

    localparam logic [6:0] OPI = 7'h13;
    localparam logic [31:0] LOOP = 32'h0000_006F;   // JAL x0,0

    // ---------------- log lookups ----------------
    function automatic logic [31:0] wr_data(input logic [31:0] addr);
        foreach (xq[i]) if (xq[i].we && xq[i].addr == addr) return xq[i].data;
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int retire_cyc(input logic [31:0] pc);
        foreach (rq_pc[i]) if (rq_pc[i] == pc) return rq_cyc[i];
        return -1;
    endfunction

    function automatic logic [31:0] xq_addr(input int i);
        if (i < xq.size()) return xq[i].addr;
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int xq_cyc(input int i);
        if (i < xq.size()) return xq[i].cyc;
        return -1;
    endfunction

    // ---------------- monitor / memory responder ----------------
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (mem_req && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (mem_req && !mem_ready)
                stall_addr.push_back(mem_addr);
            if (mem_req && mem_ready) begin
                xq.push_back('{cyc, mem_addr, mem_we, mem_we ? mem_wdata : mem_rdata});
                $display("cyc %0d: %s addr=%h data=%h", cyc, mem_we ? "write" : "read ",
                         mem_addr, mem_we ? mem_wdata : mem_rdata);
                if (mem_we)
                    mem[mem_addr[9:2]] = mem_wdata;
            end
            if (retire) begin
                rq_cyc.push_back(cyc);
                rq_pc.push_back(pc_o);
                $display("cyc %0d: retire pc=%h", cyc, pc_o);
            end
            cyc++;
        end
    end

    // ---------------- helpers ----------------
    task automatic fill();
        for (int i = 0; i < 256; i++) mem[i] = LOOP;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    task automatic do_reset(input int stalls);
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("rst_async_req", {31'b0, mem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req",   {31'b0, mem_req}, 32'd0);
        check("rst_mem_we",    {31'b0, mem_we},  32'd0);
        check("rst_mem_addr",  mem_addr,         32'd0);
        check("rst_mem_wdata", mem_wdata,        32'd0);
        check("rst_retire",    {31'b0, retire},  32'd0);
        check("rst_halted",    {31'b0, halted},  32'd0);
        check("rst_pc_o",      pc_o,             32'h100);
        xq.delete();
        rq_cyc.delete();
        rq_pc.delete();
        stall_addr.delete();
        cyc        = 0;
        stall_left = stalls;
        @(posedge clk);
        #2;
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    logic [31:0] alu_exp [12];

    initial begin
        // ---- 1: ADDI / SW / LW, single-cycle ready ----
        fill();
        put(32'h100, enc_i(5, 0, 3'b000, 1, OPI));      // ADDI x1,x0,5
        put(32'h104, enc_s(32'h80, 1, 0));              // SW x1,0x80(x0)
        put(32'h108, enc_i(-1, 0, 3'b000, 2, OPI));     // ADDI x2,x0,-1
        put(32'h10C, enc_s(8, 2, 0));                   // SW x2,8(x0)
        put(32'h110, enc_i(8, 0, 3'b010, 3, 7'h03));    // LW x3,8(x0)
        put(32'h114, enc_s(32'h84, 3, 0));              // SW x3,0x84(x0)
        do_reset(0);
        run(60);
        check("first_fetch_addr", xq_addr(0), 32'h100);
        check("first_fetch_cyc",  xq_cyc(0),  32'd0);
        check("addi_retire_cyc",  retire_cyc(32'h100), 32'd3);
        check("addi_x1",          wr_data(32'h80), 32'd5);
        check("sw_retire_cyc",    retire_cyc(32'h104), 32'd7);
        check("sw_neg1_data",     wr_data(32'h8), 32'hFFFF_FFFF);
        check("lw_retire_cyc",    retire_cyc(32'h110), 32'd20);
        check("lw_x3",            wr_data(32'h84), 32'hFFFF_FFFF);

        // ---- 2: three wait states on the first fetch ----
        do_reset(3);
        run(30);
        check("stall_count",     stall_addr.size(), 32'd3);
        foreach (stall_addr[i]) check("stall_addr_stable", stall_addr[i], 32'h100);
        check("stall_fetch_cyc", xq_cyc(0), 32'd3);
        check("stall_retire_cyc", rq_cyc.size() > 0 ? rq_cyc[0] : -1, 32'd6);
        check("stall_x1",        wr_data(32'h80), 32'd5);

        // ---- 3a: BEQ x0,x0,-8 at 0x20 ----
        fill();
        put(32'h100, enc_j(-32'hE0, 0));                // JAL x0,0x20
        put(32'h020, enc_b(3'b000, 0, 0, -8));          // BEQ x0,x0,-8
        do_reset(0);
        run(20);
        check("beq_target",     xq_addr(2), 32'h18);
        check("beq_fetch_cyc",  xq_cyc(2),  32'd7);
        check("beq_retire_cyc", retire_cyc(32'h20), 32'd6);

        // ---- 3b: BNE x0,x0,-8 at 0x20 (not taken) ----
        put(32'h020, enc_b(3'b001, 0, 0, -8));
        do_reset(0);
        run(20);
        check("bne_target",    xq_addr(2), 32'h24);
        check("bne_fetch_cyc", xq_cyc(2),  32'd7);

        // ---- 4: JAL x1,+12 at 0x40, write to x0 discarded ----
        fill();
        put(32'h100, enc_j(-32'hC0, 0));                // JAL x0,0x40
        put(32'h040, enc_j(12, 1));                     // JAL x1,+12
        put(32'h04C, enc_s(32'h80, 1, 0));              // SW x1,0x80(x0)
        put(32'h050, enc_i(7, 0, 3'b000, 0, OPI));      // ADDI x0,x0,7
        put(32'h054, enc_s(32'h84, 0, 0));              // SW x0,0x84(x0)
        put(32'h080, 32'hDEAD_BEEF);
        put(32'h084, 32'hDEAD_BEEF);
        do_reset(0);
        run(40);
        check("jal_target",     xq_addr(2), 32'h4C);
        check("jal_retire_cyc", retire_cyc(32'h40), 32'd7);
        check("jal_link",       wr_data(32'h80), 32'h44);
        check("x0_stays_zero",  wr_data(32'h84), 32'h0);

        // ---- 5a: illegal opcode 0 at 0x100 ----
        fill();
        put(32'h100, 32'h0000_0000);
        do_reset(0);
        run(30);
`ifdef CORE_MC_TRAP_EN
        check("ill_halted",   {31'b0, halted},  32'd1);
        check("ill_pc_o",     pc_o,             32'h100);
        check("ill_mem_req",  {31'b0, mem_req}, 32'd0);
        check("ill_xfers",    xq.size(),        32'd1);
        check("ill_retires",  rq_cyc.size(),    32'd0);
`else
        check("ill_nop_retire_cyc", retire_cyc(32'h100), 32'd2);
        check("ill_next_fetch",     xq_addr(1), 32'h104);
        check("ill_next_cyc",       xq_cyc(1),  32'd3);
        check("ill_halted",         {31'b0, halted}, 32'd0);
`endif

        // ---- 5b: JAL x0,+6 -> misaligned target ----
        fill();
        put(32'h100, enc_j(6, 0));
        do_reset(0);
        run(30);
`ifdef CORE_MC_TRAP_EN
        check("mis_halted",  {31'b0, halted}, 32'd1);
        check("mis_pc_o",    pc_o,            32'h100);
        check("mis_retires", rq_cyc.size(),   32'd0);
`else
        check("mis_cleared_target", xq_addr(1), 32'h104);
        check("mis_halted",         {31'b0, halted}, 32'd0);
`endif

        // ---- 6: ALU mix, LUI/AUIPC, BLTU taken; results stored to 0x80.. ----
        fill();
        put(32'h100, enc_i(-16, 0, 3'b000, 1, OPI));           // ADDI x1,x0,-16
        put(32'h104, enc_i(3, 0, 3'b000, 2, OPI));             // ADDI x2,x0,3
        put(32'h108, enc_r(7'h20, 2, 1, 3'b000, 3));           // SUB  x3,x1,x2
        put(32'h10C, enc_r(7'h20, 2, 1, 3'b101, 4));           // SRA  x4,x1,x2
        put(32'h110, enc_r(7'h00, 2, 1, 3'b101, 5));           // SRL  x5,x1,x2
        put(32'h114, enc_r(7'h00, 2, 2, 3'b001, 6));           // SLL  x6,x2,x2
        put(32'h118, enc_r(7'h00, 2, 1, 3'b010, 7));           // SLT  x7,x1,x2
        put(32'h11C, enc_r(7'h00, 2, 1, 3'b011, 8));           // SLTU x8,x1,x2
        put(32'h120, enc_i(15, 1, 3'b100, 9, OPI));            // XORI x9,x1,15
        put(32'h124, enc_i(32'h3C, 1, 3'b111, 10, OPI));       // ANDI x10,x1,0x3C
        put(32'h128, enc_i(32'h40, 2, 3'b110, 11, OPI));       // ORI  x11,x2,0x40
        put(32'h12C, enc_u(20'h12345, 12, 7'h37));             // LUI  x12,0x12345
        put(32'h130, enc_u(20'h00001, 13, 7'h17));             // AUIPC x13,1
        put(32'h134, enc_b(3'b110, 2, 1, 8));                  // BLTU x2,x1,+8
        put(32'h138, enc_i(1, 0, 3'b000, 14, OPI));            // ADDI x14,x0,1 (skipped)
        for (int k = 0; k < 12; k++) begin
            put(32'h13C + 4 * k, enc_s(32'h80 + 4 * k, 3 + k, 0));
            put(32'h080 + 4 * k, 32'hA5A5_A5A5);
        end
        alu_exp = '{32'hFFFF_FFED, 32'hFFFF_FFFE, 32'h1FFF_FFFE, 32'h0000_0018,
                    32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0030,
                    32'h0000_0043, 32'h1234_5000, 32'h0000_1130, 32'h0000_0000};
        do_reset(0);
        run(150);
        for (int k = 0; k < 12; k++)
            check($sformatf("alu_x%0d", 3 + k), mem[(32'h80 >> 2) + k], alu_exp[k]);
        check("bltu_retire_cyc", retire_cyc(32'h134), retire_cyc(32'h130) + 3);

        // Final reset also exercises leaving HALT in the trap build.
        do_reset(0);
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
